// File: rtl/tribuff_bus_pkg.sv
// Shared definitions for the tribuff_bus pad driver: direction-FSM state
// encoding and the width of the turnaround/settle counters.
package tribuff_bus_pkg;

  // Turnaround and settle counters are 4 bits: cnt loads at most 14 and settle saturates.
  localparam int unsigned CNT_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_RX      = 2'd0;
  localparam state_t ST_TURN_TX = 2'd1;
  localparam state_t ST_TX      = 2'd2;
  localparam state_t ST_TURN_RX = 2'd3;

endpackage

// File: rtl/tribuff_bus_sync_chain.sv
// Plain flop pipeline used to synchronise an asynchronous input bus.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears every stage
//   d     - raw input sampled every cycle
//   q     - output of the last stage (STAGES cycles of latency)
module tribuff_bus_sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Each stage takes the previous one; stage 0 takes the raw input.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < int'(STAGES); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(STAGES); i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tribuff_bus.sv
// Registered bidirectional pad driver. Drives io only in TX, inserts
// TURNAROUND hi-Z cycles on each direction change, and synchronises the
// pad back into the core.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   io                - WIDTH-bit pad bus, driven only while driving = 1
//   dir_req           - level request: 1 = drive, 0 = receive
//   tx_data/tx_valid  - transmit payload, accepted when tx_ready is high
//   tx_ready          - high in TX
//   rx_data           - synchronised pad value
//   rx_valid          - rx_data has settled while receiving
//   driving           - registered output enable
//   busy              - turnaround in progress
module tribuff_bus
  import tribuff_bus_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     TURNAROUND  = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] io,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             driving,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TURN_LOAD  = (TURNAROUND != 0) ? CNT_W'(TURNAROUND - 1) : '0;
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SYNC_STAGES);

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CNT_W-1:0]  settle_q,   settle_d;
  logic [WIDTH-1:0]  out_q,      out_d;
  logic              driving_q,  driving_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q,     busy_d;
  logic              rx_valid_q, rx_valid_d;

  // Direction FSM, transmit register and registered status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      ST_RX: begin
        if (dir_req) begin
          if (TURNAROUND != 0) begin
            state_d = ST_TURN_TX;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = ST_TX;
          end
        end
      end
      ST_TURN_TX: begin
        // A dropped request abandons the turnaround before io is ever driven.
        if (!dir_req) begin
          state_d = ST_RX;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TX: begin
        // A transfer on the exit cycle still lands: tx_ready was high.
        if (tx_valid && tx_ready_q) out_d = tx_data;
        if (!dir_req) begin
          if (TURNAROUND != 0) begin
            state_d = ST_TURN_RX;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = ST_RX;
          end
        end
      end
      ST_TURN_RX: begin
        // dir_req is ignored here so RX always lasts at least one cycle.
        if (cnt_q == '0) state_d = ST_RX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_RX;
    endcase

    // settle counts consecutive RX cycles after the entry cycle, saturating.
    settle_d = '0;
    if (state_q == ST_RX && state_d == ST_RX) begin
      settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + CNT_W'(1);
    end

    driving_d  = (state_d == ST_TX);
    tx_ready_d = (state_d == ST_TX);
    busy_d     = (state_d == ST_TURN_TX) || (state_d == ST_TURN_RX);
    rx_valid_d = (state_d == ST_RX) && (settle_d == SETTLE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RX;
      cnt_q      <= '0;
      settle_q   <= '0;
      out_q      <= IDLE_VAL;
      driving_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      out_q      <= out_d;
      driving_q  <= driving_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign io = driving_q ? out_q : {WIDTH{1'bz}};

  // The pad is sampled in every state, so TX data can be read back.
  tribuff_bus_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io),
    .q   (rx_data)
  );

  assign driving  = driving_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_tribuff_bus.sv
// Bench for tribuff_bus: directed vector table, turnaround/abort sequences
// on a TURNAROUND=3 instance, and randomized traffic against a reference model.
module tb_tribuff_bus;

  localparam int TB_TURN = 1;
  localparam int TB_SYNC = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TURNAROUND = 1)
  logic       rst = 1'b1, dir_req = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ext_en = 1'b0;
  logic [7:0] ext_val = 8'h00;
  wire  [7:0] io_bus;
  logic       tx_ready, rx_valid, driving, busy;
  logic [7:0] rx_data;

  assign io_bus = ext_en ? ext_val : 8'hzz;

  tribuff_bus #(.WIDTH(8), .TURNAROUND(TB_TURN), .SYNC_STAGES(TB_SYNC), .IDLE_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .io(io_bus), .dir_req(dir_req), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .driving(driving), .busy(busy)
  );

  // Second instance (TURNAROUND = 3)
  logic       rst3 = 1'b1, dir3 = 1'b0;
  wire  [7:0] io3;
  logic       tx_ready3, rx_valid3, driving3, busy3;
  logic [7:0] rx_data3;

  tribuff_bus #(.WIDTH(8), .TURNAROUND(3), .SYNC_STAGES(2), .IDLE_VAL(8'h00)) dut3 (
    .clk(clk), .rst(rst3), .io(io3), .dir_req(dir3), .tx_data(8'h5A),
    .tx_valid(1'b0), .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .driving(driving3), .busy(busy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle, expected outputs after its edge.
  typedef struct {
    logic       rst, dir, valid;
    logic [7:0] data;
    logic       ee;
    logic [7:0] ev;
    logic       e_drv, e_rdy, e_busy, e_rxv;
    logic [7:0] e_io;
    logic       rx_chk;
    logic [7:0] e_rx;
  } vec_t;

  function automatic vec_t mk(input logic r, d, v, input logic [7:0] dat, input logic ee,
                              input logic [7:0] ev, input logic drv, rdy, bsy, rxv,
                              input logic [7:0] eio, input logic rc, input logic [7:0] erx);
    vec_t t;
    t.rst = r; t.dir = d; t.valid = v; t.data = dat; t.ee = ee; t.ev = ev;
    t.e_drv = drv; t.e_rdy = rdy; t.e_busy = bsy; t.e_rxv = rxv;
    t.e_io = eio; t.rx_chk = rc; t.e_rx = erx;
    return t;
  endfunction

  // Reference model of the main instance.
  typedef enum int {M_RECV, M_GAP_TO_TX, M_SEND, M_GAP_TO_RX} mmode_e;
  mmode_e     m_mode = M_RECV;
  int         m_left = 0;
  int         m_age = 0;
  logic [7:0] m_out = 8'h00;
  logic [7:0] hist_v[$];
  bit         hist_k[$];

  task automatic model_step(input logic r, d, v, input logic [7:0] dat,
                            input logic ee, input logic [7:0] ev);
    bit         known;
    logic [7:0] seen;
    mmode_e     prev;
    known = (m_mode == M_SEND) || ee;
    seen  = (m_mode == M_SEND) ? m_out : ev;
    if (r) begin
      m_mode = M_RECV; m_left = 0; m_age = 0; m_out = 8'h00;
      hist_v.delete(); hist_k.delete();
      for (int i = 0; i < TB_SYNC; i++) begin hist_v.push_back(8'h00); hist_k.push_back(1'b1); end
      return;
    end
    hist_v.push_back(seen); hist_k.push_back(known);
    void'(hist_v.pop_front()); void'(hist_k.pop_front());
    prev = m_mode;
    case (m_mode)
      M_RECV: if (d) begin
        if (TB_TURN > 0) begin m_mode = M_GAP_TO_TX; m_left = TB_TURN; end
        else m_mode = M_SEND;
      end
      M_GAP_TO_TX: if (!d) m_mode = M_RECV;
                   else begin m_left--; if (m_left == 0) m_mode = M_SEND; end
      M_SEND: begin
        if (v) m_out = dat;
        if (!d) begin
          if (TB_TURN > 0) begin m_mode = M_GAP_TO_RX; m_left = TB_TURN; end
          else m_mode = M_RECV;
        end
      end
      M_GAP_TO_RX: begin m_left--; if (m_left == 0) m_mode = M_RECV; end
      default: m_mode = M_RECV;
    endcase
    if (m_mode == M_RECV) m_age = (prev == M_RECV) ? ((m_age < 1000) ? m_age + 1 : m_age) : 0;
  endtask

  vec_t vecs[20];
  int   n;

  initial begin
    vecs[0]  = mk(1,1,0,8'h00,0,8'h00, 0,0,0,0,8'h00,0,8'h00);
    vecs[1]  = mk(1,1,0,8'h00,0,8'h00, 0,0,0,0,8'h00,1,8'h00);
    vecs[2]  = mk(0,0,0,8'h00,0,8'h00, 0,0,0,0,8'h00,1,8'h00);
    vecs[3]  = mk(0,0,0,8'h00,0,8'h00, 0,0,0,1,8'h00,0,8'h00);
    vecs[4]  = mk(0,1,0,8'h00,0,8'h00, 0,0,1,0,8'h00,0,8'h00);
    vecs[5]  = mk(0,1,0,8'h00,0,8'h00, 1,1,0,0,8'h00,0,8'h00);
    vecs[6]  = mk(0,1,1,8'hA5,0,8'h00, 1,1,0,0,8'hA5,0,8'h00);
    vecs[7]  = mk(0,1,0,8'h5A,0,8'h00, 1,1,0,0,8'hA5,0,8'h00);
    vecs[8]  = mk(0,1,0,8'h00,0,8'h00, 1,1,0,0,8'hA5,1,8'hA5);
    vecs[9]  = mk(0,0,1,8'h77,0,8'h00, 0,0,1,0,8'h00,0,8'h00);
    vecs[10] = mk(0,0,0,8'h00,1,8'h3C, 0,0,0,0,8'h00,0,8'h00);
    vecs[11] = mk(0,0,0,8'h00,1,8'h3C, 0,0,0,0,8'h00,0,8'h00);
    vecs[12] = mk(0,0,0,8'h00,1,8'h3C, 0,0,0,1,8'h00,1,8'h3C);
    vecs[13] = mk(0,1,0,8'h00,0,8'h00, 0,0,1,0,8'h00,0,8'h00);
    vecs[14] = mk(0,1,0,8'h00,0,8'h00, 1,1,0,0,8'h77,0,8'h00);
    vecs[15] = mk(0,1,1,8'hFF,0,8'h00, 1,1,0,0,8'hFF,0,8'h00);
    vecs[16] = mk(1,1,0,8'h00,0,8'h00, 0,0,0,0,8'h00,1,8'h00);
    vecs[17] = mk(0,1,0,8'h00,0,8'h00, 0,0,1,0,8'h00,0,8'h00);
    vecs[18] = mk(0,1,0,8'h00,0,8'h00, 1,1,0,0,8'h00,0,8'h00);
    vecs[19] = mk(1,0,0,8'h00,0,8'h00, 0,0,0,0,8'h00,0,8'h00);

    @(negedge clk);
    // Directed table on the main instance
    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; dir_req = vecs[i].dir; tx_valid = vecs[i].valid;
      tx_data = vecs[i].data; ext_en = vecs[i].ee; ext_val = vecs[i].ev;
      @(negedge clk);
      chk($sformatf("vec%0d_driving", i), 8'(driving), 8'(vecs[i].e_drv));
      chk($sformatf("vec%0d_tx_ready", i), 8'(tx_ready), 8'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].e_busy));
      chk($sformatf("vec%0d_rx_valid", i), 8'(rx_valid), 8'(vecs[i].e_rxv));
      if (vecs[i].e_drv) chk($sformatf("vec%0d_io", i), io_bus, vecs[i].e_io);
      if (vecs[i].rx_chk) chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].e_rx);
    end
    ext_en = 1'b0;

    // TURNAROUND=3 instance: reset, abort, then full turnarounds
    rst3 = 1'b1; dir3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_reset_driving", 8'(driving3), 8'h00);
    chk("t3_reset_tx_ready", 8'(tx_ready3), 8'h00);
    chk("t3_reset_rx_valid", 8'(rx_valid3), 8'h00);
    chk("t3_reset_rx_data", rx_data3, 8'h00);
    rst3 = 1'b0; dir3 = 1'b0;
    @(negedge clk);
    dir3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort_busy%0d", i), 8'(busy3), 8'h01);
      chk($sformatf("abort_driving%0d", i), 8'(driving3), 8'h00);
    end
    dir3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_rx_busy%0d", i), 8'(busy3), 8'h00);
      chk($sformatf("abort_rx_driving%0d", i), 8'(driving3), 8'h00);
    end
    dir3 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!driving3 && n < 10);
    chk("t3_turn_tx_cycles", 8'(n), 8'd4);
    chk("t3_tx_ready", 8'(tx_ready3), 8'h01);
    chk("t3_tx_io", io3, 8'h00);
    dir3 = 1'b0;
    @(negedge clk);
    chk("t3_release_driving", 8'(driving3), 8'h00);
    chk("t3_release_busy", 8'(busy3), 8'h01);
    n = 1;
    while (busy3 && n < 10) begin @(negedge clk); n++; end
    chk("t3_turn_rx_cycles", 8'(n), 8'd4);

    // Randomized traffic on the main instance against the model
    for (int c = 0; c < 600; c++) begin
      logic r, d;
      bit   allow;
      r = (c == 0) || ($urandom_range(0, 59) == 0);
      d = ($urandom_range(0, 5) == 0) ? ~dir_req : dir_req;
      allow = (m_mode != M_SEND) && (r || !(m_mode == M_GAP_TO_TX && d && m_left == 1));
      rst = r; dir_req = d;
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      ext_en = allow && ($urandom_range(0, 3) != 0);
      ext_val = 8'($urandom);
      model_step(rst, dir_req, tx_valid, tx_data, ext_en, ext_val);
      @(negedge clk);
      chk("rnd_driving", 8'(driving), 8'(m_mode == M_SEND));
      chk("rnd_tx_ready", 8'(tx_ready), 8'(m_mode == M_SEND));
      chk("rnd_busy", 8'(busy), 8'(m_mode == M_GAP_TO_TX || m_mode == M_GAP_TO_RX));
      chk("rnd_rx_valid", 8'(rx_valid), 8'(m_mode == M_RECV && m_age >= TB_SYNC));
      if (m_mode == M_SEND) chk("rnd_io", io_bus, m_out);
      if (hist_k[0]) chk("rnd_rx_data", rx_data, hist_v[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tribuff_bus.md
Name: tribuff_bus

Overview:
- Parametrised, registered successor to the single-bit tri-state buffer.
- Drives or releases a WIDTH-bit bidirectional pad bus under a direction state machine, with configurable bus-turnaround dead cycles and a valid/ready transmit handshake.
- Synchronises the receive path through a configurable flop chain.
- Sits between protocol engines (e.g. a parallel Pmod interface) and the top-level inout pins.

Parameters:
- WIDTH, 8, bus width in bits (>=1).
- TURNAROUND, 1, hi-Z dead cycles on each direction change (0..15).
- SYNC_STAGES, 2, receive synchroniser depth (>=1).
- IDLE_VAL, 0, WIDTH-bit value loaded into the output register at reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- io  inout  WIDTH  pad bus; driven only in state TX, otherwise high-Z.
- dir_req  input  1  level: 1 requests drive (TX), 0 requests receive (RX).
- tx_data  input  WIDTH  data to drive.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  high in state TX only; transfer on tx_valid & tx_ready.
- rx_data  output  WIDTH  last synchroniser stage of io.
- rx_valid  output  1  rx_data is a settled sample of an externally driven bus.
- driving  output  1  registered output enable (state == TX).
- busy  output  1  high in TURN_TX or TURN_RX.

Behaviour:
- States: RX, TURN_TX, TX, TURN_RX. A 4-bit turnaround counter `cnt` and a settle counter `settle` (counts to SYNC_STAGES, saturating) are kept.
- Reset:
  - Next edge: state = RX, cnt = 0, settle = 0, out_reg = IDLE_VAL, synchroniser flops = 0.
  - Outputs: driving = 0 (io high-Z), tx_ready = 0, rx_valid = 0, busy = 0.
  - Reset mid-operation (any state) releases io on the edge it is sampled; no partial turnaround is completed.
- io = driving ? out_reg : all-Z. driving is a flop, never decoded combinationally from inputs.
- RX:
  - dir_req = 1 with TURNAROUND > 0: go to TURN_TX, cnt = TURNAROUND - 1.
  - dir_req = 1 with TURNAROUND = 0: go straight to TX.
- TURN_TX:
  - io stays high-Z; cnt decrements each cycle; at cnt = 0, go to TX.
  - dir_req falling during TURN_TX: abort to RX on the next edge. settle restarts from 0.
- TX:
  - driving = 1 and tx_ready = 1.
  - On tx_valid & tx_ready: out_reg <= tx_data. io shows the new value 1 cycle after the accepting edge.
  - Without a transfer, out_reg holds its last value, including across direction changes.
- TX exit, dir_req = 0:
  - TURNAROUND > 0: go to TURN_RX, cnt = TURNAROUND - 1; driving drops on that same edge.
  - TURNAROUND = 0: go straight to RX.
  - A transfer in that same cycle is still accepted: tx_ready was high and out_reg updates.
- TURN_RX:
  - io high-Z; cnt decrements; at cnt = 0, go to RX.
  - dir_req is ignored here; it is re-evaluated in RX, so RX is always entered for at least 1 cycle.
- Receive path:
  - The synchroniser samples io every cycle in every state (readback is allowed). rx_data = stage SYNC_STAGES-1.
  - settle clears whenever state != RX and counts up in RX.
  - rx_valid = (state == RX) & (settle == SYNC_STAGES). First rx_valid comes SYNC_STAGES cycles after entering RX.
- Width rule: no arithmetic on data; cnt and settle are 4-bit unsigned, no wrap, because cnt is loaded at most 14 and settle saturates.
- Never drive io in any cycle adjacent to a non-TX state when TURNAROUND > 0.

Decomposition:
- Shared package: state encoding localparams (RX = 2'd0, TURN_TX = 2'd1, TX = 2'd2, TURN_RX = 2'd3) and the counter width constant.
- One natural sub-module: sync_chain (WIDTH, SYNC_STAGES), a plain flop pipeline reused by other input blocks.

Test Plan:
- Reset: rst = 1 for 2 cycles with dir_req = 1 -> io = Z, driving = 0, tx_ready = 0, rx_valid = 0; state RX after release.
- RX to TX, TURNAROUND = 1: raise dir_req at cycle 0 -> busy = 1 for 1 cycle; driving and tx_ready at cycle 2; io = 8'h00 (IDLE_VAL).
- TX transfer: send tx_data = 8'hA5 and tx_valid = 1 in TX -> io = 8'hA5 the cycle after the accept; with tx_valid = 0, io holds 8'hA5.
- TX to RX: drop dir_req, external driver puts 8'h3C on io after the release edge -> io Z from the same edge; TURN_RX 1 cycle; rx_valid high 2 cycles after entering RX with rx_data = 8'h3C.
- TURN_TX abort: TURNAROUND = 3, dir_req pulsed high for 2 cycles -> driving never asserts; return to RX; io stays Z throughout.
- Reset mid-TX: assert rst while driving 8'hFF -> io Z after the next edge; out_reg = IDLE_VAL; rx_valid = 0.
